// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: shared definitions for the ALU / multiply-divide unit.
//   op_e      - 4-bit operation encodings presented on the request bus
//   state_e   - control FSM states of alu_mdu_unit
//   is_iter_op- true for the multi-cycle ops handled by mdu_iter
package alu_mdu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLT   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_MULTU = 4'd8,
        OP_DIVU  = 4'd9,
        OP_MFHI  = 4'd10,
        OP_MFLO  = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response bus of the ALU / multiply-divide unit.
//   in_valid/in_ready  - request handshake, carrying op, dataA, dataB
//   out_valid/out_ready- response handshake, carrying Output and err
//   master modport: requester side; slave modport: the unit itself.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Output;
    logic             err;

    modport master (
        output in_valid, op, dataA, dataB, out_ready,
        input  in_ready, out_valid, Output, err
    );

    modport slave (
        input  in_valid, op, dataA, dataB, out_ready,
        output in_ready, out_valid, Output, err
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: 1-bit-per-cycle unsigned multiply (shift-add) and restoring
// divide engine.
//   clk, reset  - clock and synchronous active-high reset
//   start       - load operands and begin an operation
//   is_div      - 1 = divide op_a / op_b, 0 = multiply op_a * op_b
//   op_a, op_b  - operands sampled on start
//   done        - high on the cycle the last iteration is computed
//   hi, lo      - result of the current iteration; valid when done is high
//                 (multiply: product upper/lower half, divide: remainder/quotient)
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [SHW:0] LAST_CNT = (SHW+1)'(WIDTH - 1);

    // The same three registers serve both ops:
    //   multiply: a_r = multiplicand, {p_hi_r, p_lo_r} = partial product / multiplier
    //   divide:   a_r = divisor, p_hi_r = partial remainder, p_lo_r = dividend/quotient
    logic             running_r;
    logic             div_r;
    logic [SHW:0]     cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] p_hi_r;
    logic [WIDTH-1:0] p_lo_r;

    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] hi_nxt_s;
    logic [WIDTH-1:0] lo_nxt_s;

    // One iteration of either algorithm. A zero divisor never borrows, so the
    // quotient fills with ones and the remainder collects the dividend.
    always_comb begin
        mul_sum_s   = {1'b0, p_hi_r} + (p_lo_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {p_hi_r, p_lo_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, a_r});
        if (div_r) begin
            if (div_ge_s) begin
                hi_nxt_s = div_shift_s[WIDTH-1:0] - a_r;
            end else begin
                hi_nxt_s = div_shift_s[WIDTH-1:0];
            end
            lo_nxt_s = {p_lo_r[WIDTH-2:0], div_ge_s};
        end else begin
            hi_nxt_s = mul_sum_s[WIDTH:1];
            lo_nxt_s = {mul_sum_s[0], p_lo_r[WIDTH-1:1]};
        end
    end

    // Operand load and iteration state.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_r <= 1'b0;
            div_r     <= 1'b0;
            cnt_r     <= '0;
            a_r       <= '0;
            p_hi_r    <= '0;
            p_lo_r    <= '0;
        end else if (start) begin
            running_r <= 1'b1;
            div_r     <= is_div;
            cnt_r     <= '0;
            a_r       <= is_div ? op_b : op_a;
            p_hi_r    <= '0;
            p_lo_r    <= is_div ? op_a : op_b;
        end else if (running_r) begin
            cnt_r  <= cnt_r + (SHW+1)'(1);
            p_hi_r <= hi_nxt_s;
            p_lo_r <= lo_nxt_s;
            if (cnt_r == LAST_CNT) begin
                running_r <= 1'b0;
            end
        end
    end

    assign done = running_r && (cnt_r == LAST_CNT);
    assign hi   = hi_nxt_s;
    assign lo   = lo_nxt_s;
endmodule

// File: rtl/alu_mdu_unit.sv
// alu_mdu_unit: single-cycle ALU plus iterative MULTU/DIVU with HI/LO registers.
//   clk   - clock, all state on the rising edge
//   reset - synchronous active-high reset; aborts any running operation
//   bus   - alu_mdu_if slave: request (in_valid/in_ready, op, dataA, dataB)
//           and response (out_valid/out_ready, Output, err)
// Undefined op codes answer Output=0 with err=1 and leave HI/LO untouched.
module alu_mdu_unit
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     reset,
    alu_mdu_if.slave bus
);
    state_e           state_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_r;
    logic             err_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH-1:0] alu_res_s;
    logic             alu_err_s;
    logic             mdu_start_s;
    logic             mdu_done_s;
    logic [WIDTH-1:0] mdu_hi_s;
    logic [WIDTH-1:0] mdu_lo_s;

    // Single-cycle result computed straight from the request bus.
    always_comb begin
        alu_res_s = '0;
        alu_err_s = 1'b0;
        case (bus.op)
            OP_ADD:   alu_res_s = bus.dataA + bus.dataB;
            OP_SUB:   alu_res_s = bus.dataA - bus.dataB;
            OP_AND:   alu_res_s = bus.dataA & bus.dataB;
            OP_OR:    alu_res_s = bus.dataA | bus.dataB;
            OP_SLT:   alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.dataA) < $signed(bus.dataB))};
            OP_SLL:   alu_res_s = bus.dataA << bus.dataB[SHW-1:0];
            OP_SRL:   alu_res_s = bus.dataA >> bus.dataB[SHW-1:0];
            OP_MFHI:  alu_res_s = hi_r;
            OP_MFLO:  alu_res_s = lo_r;
            OP_MULTU: alu_res_s = '0;
            OP_DIVU:  alu_res_s = '0;
            default:  alu_err_s = 1'b1;
        endcase
    end

    assign mdu_start_s = (state_r == ST_IDLE) && bus.in_valid && is_iter_op(bus.op);

    mdu_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mdu_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (mdu_start_s),
        .is_div (bus.op == OP_DIVU),
        .op_a   (bus.dataA),
        .op_b   (bus.dataB),
        .done   (mdu_done_s),
        .hi     (mdu_hi_s),
        .lo     (mdu_lo_s)
    );

    // Control FSM with registered handshake, result and HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_r       <= '0;
            err_r       <= 1'b0;
            hi_r        <= '0;
            lo_r        <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_r <= 1'b0;
                        if (is_iter_op(bus.op)) begin
                            state_r <= ST_BUSY;
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            out_r       <= alu_res_s;
                            err_r       <= alu_err_s;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mdu_done_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        out_r       <= mdu_lo_s;
                        err_r       <= 1'b0;
                        hi_r        <= mdu_hi_s;
                        lo_r        <= mdu_lo_s;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.Output    = out_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_alu_mdu_unit.sv
// tb_alu_mdu_unit: directed scoreboard bench for alu_mdu_unit (WIDTH=32).
// The driver pushes the hand-computed response of every request into a queue;
// a negedge monitor pops and compares whenever a response handshake happens,
// and also checks the cycle distance from accept to the first out_valid.
module tb_alu_mdu_unit;
    import alu_mdu_pkg::*;

    typedef struct {
        logic [31:0] out;
        logic        err;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    bit   rise_seen = 1'b0;

    alu_mdu_if #(.WIDTH(32)) bus ();

    alu_mdu_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Response monitor: latency on first rise, data and err on handshake.
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                if (!rise_seen) begin
                    rise_seen = 1'b1;
                    chk({q[0].name, "_latency"}, 32'(cyc - q[0].acc + 1), 32'(q[0].lat));
                end
                if (bus.out_ready) begin
                    chk({q[0].name, "_out"}, bus.Output, q[0].out);
                    chk({q[0].name, "_err"}, 32'(bus.err), 32'(q[0].err));
                    q.delete(0);
                    rise_seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eo, input logic ee,
                         input int lat, input bit expect_out);
        exp_t e;
        int   w = 0;
        while (!bus.in_ready && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!bus.in_ready) begin
            chk({name, "_in_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.dataA    = a;
        bus.dataB    = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (expect_out) begin
            e.out  = eo;
            e.err  = ee;
            e.lat  = lat;
            e.acc  = cyc;
            e.name = name;
            q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int w = 0;
        while (q.size() != 0 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (q.size() != 0) begin
            chk({name, "_drain_timeout"}, 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = 4'd0;
        bus.dataA     = 32'd0;
        bus.dataB     = 32'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_output",    bus.Output,         32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);

        issue("mfhi_rst", OP_MFHI, 32'd0,          32'd0,          32'd0,          1'b0, 1, 1'b1);
        issue("add_wrap", OP_ADD,  32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0000,  1'b0, 1, 1'b1);
        issue("sub_wrap", OP_SUB,  32'h0000_0000,  32'h0000_0001,  32'hFFFF_FFFF,  1'b0, 1, 1'b1);
        issue("and",      OP_AND,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0, 1, 1'b1);
        issue("or",       OP_OR,   32'h1234_0000,  32'h0000_5678,  32'h1234_5678,  1'b0, 1, 1'b1);
        issue("slt_neg",  OP_SLT,  32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0001,  1'b0, 1, 1'b1);
        issue("slt_pos",  OP_SLT,  32'h0000_0001,  32'hFFFF_FFFF,  32'h0000_0000,  1'b0, 1, 1'b1);
        issue("sll",      OP_SLL,  32'h0000_0001,  32'h0000_0024,  32'h0000_0010,  1'b0, 1, 1'b1);

        issue("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33, 1'b1);
        issue("mfhi_mul",  OP_MFHI,  32'd0,         32'd0,         32'hFFFF_FFFE, 1'b0, 1,  1'b1);
        issue("bad_op_f",  4'hF,     32'h1111_1111, 32'h2222_2222, 32'h0000_0000, 1'b1, 1,  1'b1);
        issue("mfhi_keep", OP_MFHI,  32'd0,         32'd0,         32'hFFFF_FFFE, 1'b0, 1,  1'b1);
        issue("mflo_keep", OP_MFLO,  32'd0,         32'd0,         32'h0000_0001, 1'b0, 1,  1'b1);
        issue("bad_op_7",  4'h7,     32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1, 1,  1'b1);

        issue("multu_mid", OP_MULTU, 32'd12345,     32'd6789,      32'h04FE_D79D, 1'b0, 33, 1'b1);
        issue("mfhi_mid",  OP_MFHI,  32'd0,         32'd0,         32'h0000_0000, 1'b0, 1,  1'b1);

        issue("divu_100_7", OP_DIVU, 32'd100,       32'd7,         32'd14,        1'b0, 33, 1'b1);
        issue("mfhi_rem",   OP_MFHI, 32'd0,         32'd0,         32'd2,         1'b0, 1,  1'b1);
        issue("divu_by0",   OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 33, 1'b1);
        issue("mfhi_by0",   OP_MFHI, 32'd0,         32'd0,         32'd5,         1'b0, 1,  1'b1);
        drain("pre_hold");

        // Back-pressure: result must hold and no new request be taken.
        bus.out_ready = 1'b0;
        issue("srl_hold", OP_SRL, 32'h8000_0000, 32'h0000_0023, 32'h1000_0000, 1'b0, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_output",    bus.Output,         32'h1000_0000);
            chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        drain("hold");

        // Reset ten cycles into a MULTU: no result, HI/LO cleared.
        issue("multu_abort", OP_MULTU, 32'h0000_0003, 32'h0000_0005, 32'd0, 1'b0, 33, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        issue("mflo_abort", OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 1, 1'b1);
        issue("mfhi_abort", OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 1, 1'b1);
        drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
